// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour width, address
// widths and the control-bundle layout carried alongside pixel data.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 640;
    localparam int unsigned H_FP_DEF       = 16;
    localparam int unsigned H_SYNC_DEF     = 96;
    localparam int unsigned H_BP_DEF       = 48;
    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam int unsigned V_FP_DEF       = 10;
    localparam int unsigned V_SYNC_DEF     = 2;
    localparam int unsigned V_BP_DEF       = 33;
    localparam int unsigned COLOR_W_DEF    = 3;
    localparam int unsigned FETCH_LEAD_DEF = 3;

    localparam int unsigned LINE_W   = 9;
    localparam int unsigned OFFSET_W = 10;

    // Per-position decode that travels with the frame-buffer fetch.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vga_ctrl_t;

    localparam int unsigned CTRL_W = $bits(vga_ctrl_t);

    // True when pos lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency shift register; clears to zero on reset.
// Ports: clk_i, reset_i (async active-high), d_i (WIDTH), q_o (d_i delayed DEPTH clocks).
module vga_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame-buffer address output and optional
// 2x pixel/line doubling. Sync/de/frame_start are delayed to line up with the
// frame-buffer read data so every output describes the same raster position.
// Ports: clk, reset (async active-high), scale2x (doubling request, sampled
// at end of frame), pixel_in (frame-buffer data); line/offset (fetch address),
// color, hsync, vsync, de, frame_start (all registered).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0,
    parameter int unsigned COLOR_W    = COLOR_W_DEF,
    parameter int unsigned FETCH_LEAD = FETCH_LEAD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scale2x,
    input  logic [COLOR_W-1:0]  pixel_in,
    output logic [LINE_W-1:0]   line,
    output logic [OFFSET_W-1:0] offset,
    output logic [COLOR_W-1:0]  color,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0]       hcount_q, hcount_d;
    logic [VW-1:0]       vcount_q, vcount_d;
    logic                scale_q, scale_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [COLOR_W-1:0]  color_q;
    logic                hsync_q, vsync_q, de_q, fs_q;

    logic      h_last, v_last, active;
    vga_ctrl_t ctrl_now, ctrl_dly;

    assign h_last = (hcount_q == HW'(H_TOTAL - 1));
    assign v_last = (vcount_q == VW'(V_TOTAL - 1));
    assign active = (hcount_q < HW'(H_ACTIVE)) && (vcount_q < VW'(V_ACTIVE));

    // Raster counters; scale mode only changes as the frame wraps.
    always_comb begin
        hcount_d = hcount_q + HW'(1);
        vcount_d = vcount_q;
        scale_d  = scale_q;
        if (h_last) begin
            hcount_d = '0;
            vcount_d = v_last ? '0 : vcount_q + VW'(1);
            if (v_last) begin
                scale_d = scale2x;
            end
        end
    end

    // Fetch address for the current position; zero outside active video.
    always_comb begin
        line_d   = '0;
        offset_d = '0;
        if (active) begin
            if (scale_q) begin
                line_d   = LINE_W'(vcount_q >> 1);
                offset_d = OFFSET_W'(hcount_q >> 1);
            end else begin
                line_d   = LINE_W'(vcount_q);
                offset_d = OFFSET_W'(hcount_q);
            end
        end
    end

    // Undelayed decode of the current position (sync in true sense, polarity applied at output).
    always_comb begin
        ctrl_now.hs = in_window(32'(hcount_q), H_ACTIVE + H_FP, H_SYNC);
        ctrl_now.vs = in_window(32'(vcount_q), V_ACTIVE + V_FP, V_SYNC);
        ctrl_now.de = active;
        ctrl_now.fs = (hcount_q == '0) && (vcount_q == '0);
    end

    // Match the frame-buffer read latency so decode lands with pixel_in.
    vga_delay_line #(
        .WIDTH (CTRL_W),
        .DEPTH (FETCH_LEAD)
    ) u_ctrl_dly (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (ctrl_now),
        .q_o     (ctrl_dly)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
            scale_q  <= 1'b0;
            line_q   <= '0;
            offset_q <= '0;
            color_q  <= '0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            scale_q  <= scale_d;
            line_q   <= line_d;
            offset_q <= offset_d;
            color_q  <= ctrl_dly.de ? pixel_in : '0;
            hsync_q  <= ctrl_dly.hs ? HS_POL : ~HS_POL;
            vsync_q  <= ctrl_dly.vs ? VS_POL : ~VS_POL;
            de_q     <= ctrl_dly.de;
            fs_q     <= ctrl_dly.fs;
        end
    end

    assign line        = line_q;
    assign offset      = offset_q;
    assign color       = color_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch, sync width and back porch in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch, sync width and back porch in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, sync active level (0 = active-low).
REQ-006 SHALL have parameter COLOR_W, default 3, colour width; {R,G,B} packing for 3.
REQ-007 SHALL have parameter FETCH_LEAD, default 3, range 1..8, frame-buffer read latency in clocks.
REQ-008 SHALL have port clk, input, 1, pixel clock (25 MHz at defaults).
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port scale2x, input, 1, pixel/line doubling request.
REQ-011 SHALL have port pixel_in, input, COLOR_W, frame-buffer data.
REQ-012 SHALL have port line, output, 9, frame-buffer row address.
REQ-013 SHALL have port offset, output, 10, frame-buffer column address.
REQ-014 SHALL have port color, output, COLOR_W, pixel colour to DAC.
REQ-015 SHALL have ports hsync and vsync, output, 1 each, sync pulses.
REQ-016 SHALL have ports de and frame_start, output, 1 each: active-video flag; one-clock pulse on the first pixel of a frame.

Function
REQ-017 SHALL keep hcount 0..H_TOTAL-1 (H_TOTAL = sum of H parameters), incrementing every clock, and vcount 0..V_TOTAL-1, incrementing when hcount wraps.
REQ-018 SHALL order regions active, front porch, sync, back porch on both axes; active = hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-019 SHALL register line/offset from (vcount,hcount) each clock when active, else drive both 0.
REQ-020 SHALL, in scale mode, drive line=vcount>>1 and offset=hcount>>1.
REQ-021 SHALL sample scale2x only when hcount=H_TOTAL-1 and vcount=V_TOTAL-1; mode SHALL be constant for the whole frame.
REQ-022 SHALL delay the hsync, vsync, de and frame_start decodes through a FETCH_LEAD-deep pipeline so they align with pixel_in.
REQ-023 SHALL sample pixel_in exactly FETCH_LEAD clocks after its line/offset appeared, register it to color when delayed de=1, else color=0.
REQ-024 SHALL make color, hsync, vsync, de and frame_start all describe the same (hcount,vcount), FETCH_LEAD+1 clocks after that position is counted.
REQ-025 SHALL assert hsync at HS_POL for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on vcount with VS_POL.
REQ-026 SHALL generate frame_start for position (0,0) only; it SHALL coincide with the first de=1 clock of the frame.
REQ-027 SHALL wrap both counters to 0 on the same clock at (H_TOTAL-1, V_TOTAL-1) with no skipped or repeated clock.

Reset
REQ-028 SHALL, while reset=1, hold hcount=0, vcount=0, scale mode=0, line=0, offset=0, color=0, de=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL, pipeline cleared.
REQ-029 SHALL, on reset mid-frame, abandon the frame; first clock after release counts (0,0), and frame_start follows FETCH_LEAD+1 clocks later.

Structure
REQ-030 SHALL place default timing constants and COLOR_W in shared package vga_pkg, reused by frame-buffer and test modules.
REQ-031 SHALL implement the delay line as sub-module vga_delay_line (parametrised width and depth); counters and decode stay in vga_timing_gen.

Verification
REQ-032 Defaults, run 2 frames -> H period 800 clk, hsync low 96 clk; V period 420000 clk, vsync low 1600 clk; 307200 de=1 clocks per frame.
REQ-033 pixel_in = offset[2:0] model with FETCH_LEAD=3 -> color on each de clock equals that pixel's column mod 8; color=0 whenever de=0.
REQ-034 scale2x=1 raised mid-frame -> no change until next frame; then line max 239, offset max 319, each address held 2 clocks / 2 lines.
REQ-035 reset pulse at vcount=200, hcount=300 -> outputs at REQ-028 values during reset; frame_start exactly 4 clocks after release.
REQ-036 HS_POL=1, VS_POL=1, H_ACTIVE=320, V_ACTIVE=240 -> sync pulses active-high at same widths; H period 480 clk.
